// File: rtl/ibex_instr_aligner.sv
// Instruction aligner: turns word-aligned fetch words into one RVC or 32-bit instruction per cycle.
// Optional fetch-error tracking is enabled with `define IBEX_ALIGNER_FETCH_ERR_EN.
module ibex_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
    input  logic        fetch_err_i,
    output logic        instr_fetch_err_o,
`endif
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_compressed_o
);

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        HALF  = 2'd1,
        SKIP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [31:0] pc_q, pc_d;
    logic        word_err;

`ifdef IBEX_ALIGNER_FETCH_ERR_EN
    logic buf_err_q, buf_err_d;
    assign word_err = fetch_err_i;
`else
    assign word_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        buf_d         = buf_q;
        pc_d          = pc_q;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = fetch_rdata_i;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
        buf_err_d         = buf_err_q;
        instr_fetch_err_o = 1'b0;
`endif
        if (!rst_ni) begin
            // Outputs stay quiet while reset is asserted; the register block reloads state.
        end else if (redirect_i) begin
            fetch_ready_o = 1'b1;
            pc_d          = {redirect_pc_i[31:1], 1'b0};
            state_d       = redirect_pc_i[1] ? SKIP : ALIGN;
            buf_d         = '0;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
            buf_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ALIGN: begin
                    instr_valid_o = fetch_valid_i;
                    fetch_ready_o = instr_ready_i;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                    instr_fetch_err_o = fetch_err_i;
`endif
                    // An errored word is passed on whole so the error is reported exactly once.
                    if (fetch_rdata_i[1:0] != 2'b11 && !word_err) begin
                        instr_rdata_o = {16'h0000, fetch_rdata_i[15:0]};
                        if (fetch_valid_i && instr_ready_i) begin
                            buf_d   = fetch_rdata_i[31:16];
                            state_d = HALF;
                            pc_d    = pc_q + 32'd2;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                            buf_err_d = fetch_err_i;
`endif
                        end
                    end else if (fetch_valid_i && instr_ready_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                HALF: begin
                    if (buf_q[1:0] != 2'b11) begin
                        instr_rdata_o = {16'h0000, buf_q};
                        instr_valid_o = 1'b1;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                        instr_fetch_err_o = buf_err_q;
`endif
                        if (instr_ready_i) begin
                            state_d = ALIGN;
                            pc_d    = pc_q + 32'd2;
                        end
                    end else begin
                        // Straddling instruction: low half buffered, high half in the new word.
                        instr_rdata_o = {fetch_rdata_i[15:0], buf_q};
                        instr_valid_o = fetch_valid_i;
                        fetch_ready_o = instr_ready_i;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                        instr_fetch_err_o = buf_err_q | fetch_err_i;
`endif
                        if (fetch_valid_i && instr_ready_i) begin
                            buf_d = fetch_rdata_i[31:16];
                            pc_d  = pc_q + 32'd4;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                            buf_err_d = fetch_err_i;
`endif
                        end
                    end
                end
                SKIP: begin
                    fetch_ready_o = 1'b1;
                    if (fetch_valid_i) begin
                        buf_d   = fetch_rdata_i[31:16];
                        state_d = HALF;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                        buf_err_d = fetch_err_i;
`endif
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q <= BOOT_ADDR[1] ? SKIP : ALIGN;
            buf_q   <= '0;
            pc_q    <= BOOT_ADDR;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
            buf_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
            buf_err_q <= buf_err_d;
`endif
        end
    end

    assign instr_pc_o            = pc_q;
    assign instr_is_compressed_o = (instr_rdata_o[1:0] != 2'b11);

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Scoreboard bench for ibex_instr_aligner: a halfword memory model predicts the instruction stream
// from each start PC; a monitor pops and compares on every accepted instruction.
module tb_ibex_instr_aligner;
    localparam logic [31:0] BOOT   = 32'h0000_0080;
    localparam int          N_PUSH = 80;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_compressed_o;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
    logic        fetch_err_i = 1'b0;
    logic        instr_fetch_err_o;
`endif

    always #5 clk = ~clk;

    ibex_instr_aligner #(.BOOT_ADDR(BOOT)) dut (
        .clk                   (clk),
        .rst_ni                (rst_ni),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_rdata_i         (fetch_rdata_i),
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
        .fetch_err_i           (fetch_err_i),
        .instr_fetch_err_o     (instr_fetch_err_o),
`endif
        .redirect_i            (redirect_i),
        .redirect_pc_i         (redirect_pc_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_pc_o            (instr_pc_o),
        .instr_is_compressed_o (instr_is_compressed_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem [1024];
    logic [31:0] fetch_addr = BOOT;
    logic        last_fire = 1'b0;
    logic        last_redirect = 1'b0;
    logic        last_rst = 1'b1;
    logic [31:0] last_rpc = '0;
    int          total = 0;
    int          passed = 0;

    function automatic int idx(input logic [31:0] a);
        return int'(a[10:1]);
    endfunction

    function automatic void put_word(input logic [31:0] a, input logic [31:0] w);
        mem[idx(a)]         = w[15:0];
        mem[idx(a + 32'd2)] = w[31:16];
    endfunction

    // Program-order view: instruction length comes from the low two bits of its first halfword.
    function automatic void push_stream(input logic [31:0] start);
        logic [31:0] pc;
        pc = start & ~32'h1;
        sb.delete();
        for (int i = 0; i < N_PUSH; i++) begin
            logic [15:0] lo;
            exp_t        e;
            lo   = mem[idx(pc)];
            e.pc = pc;
            if (lo[1:0] != 2'b11) begin
                e.instr = {16'h0000, lo};
                pc      = pc + 32'd2;
            end else begin
                e.instr = {mem[idx(pc + 32'd2)], lo};
                pc      = pc + 32'd4;
            end
            sb.push_back(e);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Fetch-side memory model plus one cycle of stimulus; returns at the following negedge.
    task automatic drive(input logic rn, input logic rd, input logic [31:0] rpc,
                         input logic fv, input logic ir);
        @(posedge clk);
        #1;
        if (last_rst) fetch_addr = BOOT & ~32'h3;
        else if (last_redirect) fetch_addr = last_rpc & ~32'h3;
        else if (last_fire) fetch_addr = fetch_addr + 32'd4;
        rst_ni        = rn;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        fetch_valid_i = fv;
        instr_ready_i = ir;
        fetch_rdata_i = {mem[idx(fetch_addr + 32'd2)], mem[idx(fetch_addr)]};
        if (!rn) push_stream(BOOT);
        else if (rd) push_stream(rpc);
        @(negedge clk);
        last_fire     = rn && fv && fetch_ready_o;
        last_redirect = rn && rd;
        last_rst      = !rn;
        last_rpc      = rpc;
    endtask

    always @(negedge clk) begin
        if (rst_ni && redirect_i) begin
            check("redirect_valid", 32'(instr_valid_o), 32'd0);
        end else if (rst_ni && instr_valid_o && instr_ready_i) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_instr: got pc %h data %h expected no instruction", instr_pc_o, instr_rdata_o);
            end else begin
                mon_e = sb.pop_front();
                check("instr_pc", instr_pc_o, mon_e.pc);
                check("instr_rdata", instr_rdata_o, mon_e.instr);
                check("is_compressed", 32'(instr_is_compressed_o), 32'(mon_e.instr[1:0] != 2'b11));
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
                check("fetch_err", 32'(instr_fetch_err_o), 32'd0);
`endif
            end
        end
    end

    initial begin
        logic        frdy [11];
        logic        ir;
        logic [31:0] rpc;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        put_word(32'h80, 32'h00A00093);
        put_word(32'h84, 32'h45010505);
        put_word(32'h88, 32'h00930505);
        put_word(32'h8C, 32'h450100A0);
        put_word(32'h100, 32'h45010505);

        // Reset: nothing offered, nothing consumed.
        repeat (2) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            check("reset_valid", 32'(instr_valid_o), 32'd0);
            check("reset_fetch_ready", 32'(fetch_ready_o), 32'd0);
        end

        // Aligned, RVC pair, straddle, then 5 cycles of backpressure on the straddle.
        frdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 11; c++) begin
            ir = !(c >= 4 && c <= 8);
            drive(1'b1, 1'b0, '0, 1'b1, ir);
            check("dir_fetch_ready", 32'(fetch_ready_o), 32'(frdy[c]));
            if (!ir) begin
                check("hold_valid", 32'(instr_valid_o), 32'd1);
                check("hold_rdata", instr_rdata_o, 32'h00A00093);
                check("hold_pc", instr_pc_o, 32'h0000_008A);
            end
        end

        // Reset while a straddling low half sits in the buffer.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("midhalf_reset_valid", 32'(instr_valid_o), 32'd0);
        check("midhalf_reset_fetch_ready", 32'(fetch_ready_o), 32'd0);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("post_reset_pc", instr_pc_o, 32'h0000_0080);
        check("post_reset_rdata", instr_rdata_o, 32'h00A00093);
        repeat (5) drive(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Redirect to an odd halfword while an instruction is on offer.
        drive(1'b1, 1'b1, 32'h0000_0102, 1'b1, 1'b1);
        check("redirect_fetch_ready", 32'(fetch_ready_o), 32'd1);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("skip_valid", 32'(instr_valid_o), 32'd0);
        check("skip_fetch_ready", 32'(fetch_ready_o), 32'd1);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("odd_target_valid", 32'(instr_valid_o), 32'd1);
        check("odd_target_pc", instr_pc_o, 32'h0000_0102);
        check("odd_target_rdata", instr_rdata_o, 32'h0000_4501);

        // Random segments: random targets (some near the 2^32 wrap, some with bit 0 set) and handshakes.
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 7)) * 32'd2;
            else rpc = 32'($urandom_range(0, 1023)) * 32'd2 | 32'($urandom_range(0, 1));
            drive(1'b1, 1'b1, rpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                drive(1'b1, 1'b0, '0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ibex_instr_aligner.md
# ibex_instr_aligner

Instruction aligner that sits between the fetch buffer and the compressed-instruction decoder. It takes a stream of 32-bit, word-aligned fetch words. From them it extracts one RVC (16-bit) or full (32-bit) instruction per cycle, including 32-bit instructions that straddle two fetch words. It tracks the PC of each emitted instruction and handles redirects to halfword-aligned targets. Its output drives the decoder input directly; the decoder expands RVC instructions downstream.

## Interface
- `BOOT_ADDR`, default 32'h0000_0080: PC loaded on reset; bit 1 honoured (odd-halfword boot enters SKIP).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `fetch_valid_i`  in  1  fetch word valid.
- `fetch_ready_o`  out  1  fetch word consumed this cycle (when `fetch_valid_i`=1).
- `fetch_rdata_i`  in  32  fetch word, little-endian halfwords.
- `redirect_i`  in  1  flush and restart at `redirect_pc_i`.
- `redirect_pc_i`  in  32  new PC; bit 0 ignored.
- `instr_valid_o`  out  1  instruction available.
- `instr_ready_i`  in  1  decoder accepts instruction.
- `instr_rdata_o`  out  32  instruction; RVC is zero-extended to 32 bits.
- `instr_pc_o`  out  32  PC of `instr_rdata_o`.
- `instr_is_compressed_o`  out  1  `instr_rdata_o[1:0] != 2'b11`.

## Operation

**State**
- FSM `state_q` ∈ {ALIGN, HALF, SKIP}.
- 16-bit `buf_q`, which is valid only in HALF.
- 32-bit `pc_q`.

**ALIGN (buffer empty)**
- Source is `fetch_rdata_i`; `instr_valid_o` = `fetch_valid_i`.
- If `[1:0] != 11` (RVC):
  - Emit `{16'h0, rdata[15:0]}`.
  - On accept: `buf_q` ← `rdata[31:16]`, go to HALF, `pc_q` += 2.
- Else (32-bit):
  - Emit `rdata`.
  - On accept: stay in ALIGN, `pc_q` += 4.
- `fetch_ready_o` = `instr_ready_i`; the word is always consumed on accept.

**HALF, `buf_q` is RVC**
- Emit `{16'h0, buf_q}` with `instr_valid_o`=1, independent of fetch.
- `fetch_ready_o`=0.
- On accept: go to ALIGN, `pc_q` += 2.

**HALF, `buf_q` is the low half of a 32-bit instruction**
- Emit `{rdata[15:0], buf_q}`; `instr_valid_o` = `fetch_valid_i`.
- `fetch_ready_o` = `instr_ready_i`.
- On accept: `buf_q` ← `rdata[31:16]`, stay in HALF, `pc_q` += 4.

**SKIP (after a redirect to PC[1]=1)**
- `instr_valid_o`=0, `fetch_ready_o`=1.
- On a fetch word: `buf_q` ← `rdata[31:16]`, go to HALF; `pc_q` unchanged.

**Redirect**
- When `redirect_i`=1: `instr_valid_o`=0, `fetch_ready_o`=1. Any fetch word presented that cycle is discarded.
- Next state: `pc_q` ← `{redirect_pc_i[31:1], 1'b0}`; `state_q` ← SKIP if `redirect_pc_i[1]`, else ALIGN; buffer invalidated.
- Redirect has priority over a simultaneous accept; the accept is ignored.

**Arithmetic**
- `pc_q` increments wrap modulo 2^32. For example, 32'hFFFF_FFFE + 2 gives 0.
- `instr_pc_o` = `pc_q`.

## Timing
- Combinational fetch→instr path: 0-cycle latency; the only state is `state_q`, `buf_q` and `pc_q`.
- `fetch_ready_o` depends combinationally on `instr_ready_i`. The fetch buffer must not derive `fetch_valid_i` from `fetch_ready_o`.
- Throughput: 1 instruction/cycle while `fetch_valid_i`, `instr_ready_i` are held high. An RVC pair costs 2 cycles for one fetch word.
- SKIP costs exactly one cycle per fetch word.
- Outputs are stable while `instr_valid_o`=1 and `instr_ready_i`=0, provided the fetch side holds its word.
- Reset (`rst_ni`=0 at an edge): next state ALIGN or SKIP per `BOOT_ADDR[1]`, `pc_q`=`BOOT_ADDR`, `buf_q`=0.
- While `rst_ni`=0, `instr_valid_o`=0 and `fetch_ready_o`=0.
- Reset mid-instruction (including HALF with a straddling low half) discards the buffer without emitting it.

## Configuration
- Macro: `IBEX_ALIGNER_FETCH_ERR_EN`.
- **Defined:**
  - Adds `fetch_err_i` (in, 1) and `instr_fetch_err_o` (out, 1), plus a `buf_err_q` bit that travels with `buf_q`.
  - `instr_fetch_err_o` = OR of the error bits of every halfword contributing to the instruction.
  - An errored word in ALIGN is emitted whole as one 32-bit instruction (`pc_q` += 4), regardless of `[1:0]`.
  - Redirect and reset clear `buf_err_q`.
- **Undefined:** ports and `buf_err_q` are absent; behaviour is otherwise identical.

## Test plan
- **Aligned 32-bit:** reset with `BOOT_ADDR`=0x80, then word 0x00A00093 → `instr_rdata_o`=0x00A00093, pc 0x80, compressed 0, `fetch_ready_o`=1; next pc 0x84.
- **RVC pair:** word 0x45010505 → 0x00000505 @0x80, then 0x00004501 @0x82. The word is consumed at the first accept; `fetch_ready_o`=0 on the second cycle.
- **Straddle:** words 0x00930505, 0x450100A0 → 0x0505 @0x80, then 0x00A00093 @0x82, then 0x4501 @0x86.
- **Odd redirect:** `redirect_i` with pc 0x102 while an instruction is valid → no accept; then word 0x45010505 is skipped for one cycle; then 0x00004501 @0x102.
- **Backpressure:** `instr_ready_i`=0 for 5 cycles in HALF (straddle) → outputs and `fetch_ready_o`=0 stable; `pc_q` unchanged.
- **Reset mid-HALF:** `rst_ni`=0 for one cycle → `instr_valid_o`=0 that cycle; afterwards pc 0x80, the buffered half is discarded, and there is no spurious instruction.
